// File: rtl/golf_pkg.sv
// Shared terrain, probe and fixed-point definitions for the golf terrain logic.
package golf_pkg;

    localparam int FRAC_BITS  = 8;
    localparam int NUM_PROBES = 5;

    typedef enum logic [1:0] {
        TERRAIN_FAIRWAY = 2'd0,
        TERRAIN_SAND    = 2'd1,
        TERRAIN_WALL    = 2'd2,
        TERRAIN_HOLE    = 2'd3
    } terrain_t;

    // PROBE_AUX tags returning data that belongs to the auxiliary requester.
    typedef enum logic [2:0] {
        PROBE_C   = 3'd0,
        PROBE_R   = 3'd1,
        PROBE_L   = 3'd2,
        PROBE_U   = 3'd3,
        PROBE_D   = 3'd4,
        PROBE_AUX = 3'd7
    } probe_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/valid_delay_line.sv
// Shift register that tracks which outstanding BRAM read owns the data on mem_dout.
module valid_delay_line #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned TAG_W = 3
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             push_valid,
    input  logic [TAG_W-1:0] push_tag,
    output logic             pop_valid,
    output logic [TAG_W-1:0] pop_tag
);

    logic [DEPTH-1:0] valid_q;
    logic [TAG_W-1:0] tag_q [DEPTH];

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) tag_q[i] <= '0;
        end else begin
            valid_q[0] <= push_valid;
            tag_q[0]   <= push_tag;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                tag_q[i]   <= tag_q[i-1];
            end
        end
    end

    assign pop_valid = valid_q[DEPTH-1];
    assign pop_tag   = tag_q[DEPTH-1];

endmodule

// File: rtl/terrain_probe_sequencer.sv
// Five-point terrain probe around the ball with an idle-time auxiliary BRAM read port.
module terrain_probe_sequencer
    import golf_pkg::*;
#(
    parameter int WIDTH        = 128,
    parameter int HEIGHT       = 128,
    parameter int BALL_RADIUS  = 2,
    parameter int READ_LATENCY = 2,
    parameter int ADDR_W       = $clog2(WIDTH*HEIGHT)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start,
    input  logic [15:0]       ball_x,
    input  logic [15:0]       ball_y,
    output logic              busy,
    output logic              done,
    output logic [1:0]        terrain_c,
    output logic [1:0]        terrain_r,
    output logic [1:0]        terrain_l,
    output logic [1:0]        terrain_u,
    output logic [1:0]        terrain_d,
    output logic              wall_x,
    output logic              wall_y,
    output logic              in_hole,
    input  logic              aux_req,
    input  logic [ADDR_W-1:0] aux_addr,
    output logic              aux_gnt,
    output logic              aux_rvalid,
    output logic [1:0]        aux_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [1:0]        mem_dout
);

    state_t            state;
    logic [7:0]        xi, yi;
    logic [2:0]        k;
    logic [3:0]        drain_cnt;
    logic [4:0]        oob_mask;
    logic [1:0]        res      [NUM_PROBES];
    logic [1:0]        res_next [NUM_PROBES];
    logic [ADDR_W-1:0] addr_hold, probe_addr;
    logic              probe_oob;
    int                px, py, addr_full;
    logic              push_valid, pop_valid;
    logic [2:0]        push_tag, pop_tag;
    logic              unused_frac;

    assign unused_frac = ^{ball_x[FRAC_BITS-1:0], ball_y[FRAC_BITS-1:0]};

    // Signed integer coordinates so off-map probes (negative or past the edge) are detectable.
    always_comb begin
        px = int'(xi);
        py = int'(yi);
        case (k)
            PROBE_R: px = px + BALL_RADIUS;
            PROBE_L: px = px - BALL_RADIUS;
            PROBE_U: py = py - BALL_RADIUS;
            PROBE_D: py = py + BALL_RADIUS;
            default: ;
        endcase
        probe_oob  = (px < 0) || (px >= WIDTH) || (py < 0) || (py >= HEIGHT);
        addr_full  = px + (WIDTH * py);
        probe_addr = ADDR_W'(addr_full);
    end

    assign aux_gnt = aux_req && (state == ST_IDLE) && !start;

    always_comb begin
        if (state == ST_ISSUE)  mem_addr = probe_addr;
        else if (aux_gnt)       mem_addr = aux_addr;
        else                    mem_addr = addr_hold;
    end

    assign push_valid = (state == ST_ISSUE) || aux_gnt;
    assign push_tag   = (state == ST_ISSUE) ? k : PROBE_AUX;

    valid_delay_line #(
        .DEPTH (READ_LATENCY),
        .TAG_W (3)
    ) u_valid_delay_line (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .push_valid (push_valid),
        .push_tag   (push_tag),
        .pop_valid  (pop_valid),
        .pop_tag    (pop_tag)
    );

    assign aux_rvalid = pop_valid && (pop_tag == PROBE_AUX);
    assign aux_rdata  = aux_rvalid ? mem_dout : '0;

    // The last probe returns on the same edge that publishes results, so outputs load from res_next.
    always_comb begin
        for (int unsigned i = 0; i < NUM_PROBES; i++) begin
            res_next[i] = res[i];
            if (pop_valid && (pop_tag == 3'(i)))
                res_next[i] = oob_mask[i] ? TERRAIN_WALL : mem_dout;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            k         <= '0;
            drain_cnt <= '0;
            xi        <= '0;
            yi        <= '0;
            oob_mask  <= '0;
            addr_hold <= '0;
            for (int unsigned i = 0; i < NUM_PROBES; i++) res[i] <= '0;
            terrain_c <= '0;
            terrain_r <= '0;
            terrain_l <= '0;
            terrain_u <= '0;
            terrain_d <= '0;
            wall_x    <= 1'b0;
            wall_y    <= 1'b0;
            in_hole   <= 1'b0;
        end else begin
            addr_hold <= mem_addr;
            done      <= 1'b0;
            for (int unsigned i = 0; i < NUM_PROBES; i++) res[i] <= res_next[i];
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        xi    <= ball_x[15:FRAC_BITS];
                        yi    <= ball_y[15:FRAC_BITS];
                        k     <= '0;
                        busy  <= 1'b1;
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    oob_mask[k] <= probe_oob;
                    if (k == 3'(NUM_PROBES-1)) begin
                        k         <= '0;
                        drain_cnt <= '0;
                        state     <= ST_DRAIN;
                    end else begin
                        k <= k + 3'd1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == 4'(READ_LATENCY-1)) begin
                        state     <= ST_DONE;
                        done      <= 1'b1;
                        terrain_c <= res_next[PROBE_C];
                        terrain_r <= res_next[PROBE_R];
                        terrain_l <= res_next[PROBE_L];
                        terrain_u <= res_next[PROBE_U];
                        terrain_d <= res_next[PROBE_D];
                        wall_x    <= (res_next[PROBE_R] == TERRAIN_WALL) || (res_next[PROBE_L] == TERRAIN_WALL);
                        wall_y    <= (res_next[PROBE_U] == TERRAIN_WALL) || (res_next[PROBE_D] == TERRAIN_WALL);
                        in_hole   <= (res_next[PROBE_C] == TERRAIN_HOLE);
                    end else begin
                        drain_cnt <= drain_cnt + 4'd1;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/terrain_probe_sequencer.md
Name: terrain_probe_sequencer

Overview:
Owns the single-port terrain-map BRAM (2-bit codes, WIDTH*HEIGHT entries). On each `start` (one per frame from gameplay), it latches the ball position. It then issues five pipelined reads (centre, right, left, up, down) and returns per-probe terrain codes plus collision/hole flags. While idle, it lends the BRAM port to an auxiliary requester (minimap/renderer) with fixed latency.

Parameters:
- WIDTH, 128, map width in pixels
- HEIGHT, 128, map height in pixels
- BALL_RADIUS, 2, probe offset from centre, integer pixels
- READ_LATENCY, 2, BRAM address-to-data latency in cycles
- ADDR_W, $clog2(WIDTH*HEIGHT) = 14, BRAM address width

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous, active-low reset
- start  input  1  probe request pulse; accepted only in IDLE
- ball_x  input  16  ball x, 8.8 fixed point
- ball_y  input  16  ball y, 8.8 fixed point
- busy  output  1  probe sequence in progress
- done  output  1  one-cycle pulse; results valid
- terrain_c, terrain_r, terrain_l, terrain_u, terrain_d  output  2 each  probe terrain codes
- wall_x  output  1  terrain_r==WALL or terrain_l==WALL
- wall_y  output  1  terrain_u==WALL or terrain_d==WALL
- in_hole  output  1  terrain_c==HOLE
- aux_req  input  1  auxiliary read request
- aux_addr  input  ADDR_W  auxiliary address
- aux_gnt  output  1  auxiliary request granted this cycle (combinational)
- aux_rvalid  output  1  aux data valid
- aux_rdata  output  2  aux read data
- mem_addr  output  ADDR_W  BRAM address
- mem_dout  input  2  BRAM read data

Behaviour:
- Reset (rst_in==0 at posedge):
  - state goes to IDLE.
  - busy, done, aux_rvalid, flags, and all terrain_* outputs are cleared to 0.
  - The valid-tracking pipeline is flushed; any in-flight reads are discarded.
  - Reset mid-sequence produces no done pulse.
- States:
  - IDLE → ISSUE on start.
  - ISSUE lasts 5 cycles, probe index k=0..4 (c, r, l, u, d), then goes to DRAIN.
  - DRAIN lasts READ_LATENCY cycles, then goes to DONE.
  - DONE lasts 1 cycle, then returns to IDLE.
- Timing for start sampled in cycle T:
  - Probe k address is on mem_addr in cycle T+1+k.
  - Data is captured from mem_dout at the end of cycle T+1+k+READ_LATENCY.
  - done=1 and all outputs/flags are updated in cycle T+6+READ_LATENCY (T+8 at default).
  - busy=1 from T+1 through the done cycle inclusive.
- Position latch: the integer parts xi=ball_x[15:8] and yi=ball_y[15:8] are latched in cycle T. Later input changes have no effect.
- Probe coordinates:
  - c = (xi, yi)
  - r = (xi+R, yi)
  - l = (xi−R, yi)
  - u = (xi, yi−R)
  - d = (xi, yi+R)
- Address = x + WIDTH*y, computed with explicit parenthesisation at full width before truncation to ADDR_W.
- Out-of-bounds probe (coordinate <0 or ≥WIDTH/HEIGHT): the result is forced to TERRAIN_WALL and mem_dout is ignored. The issue slot is still consumed, so timing is fixed.
- start while busy (including the DONE cycle) is ignored, not queued.
- Terrain outputs hold their values until the next done or reset.
- Aux port:
  - aux_gnt = aux_req & IDLE & ~start; start wins ties.
  - When granted, mem_addr = aux_addr in that cycle.
  - aux_rvalid pulses exactly READ_LATENCY cycles after the grant, with aux_rdata = mem_dout.
  - Back-to-back grants give back-to-back rvalid pulses.
- mem_addr when idle and ungranted: holds the last value.

Decomposition:
- Shared package golf_pkg holds:
  - terrain enum: TERRAIN_FAIRWAY=0, TERRAIN_SAND=1, TERRAIN_WALL=2, TERRAIN_HOLE=3
  - probe index enum (PROBE_C..PROBE_D)
  - the fixed-point format constants (FRAC_BITS=8)
- One sub-module, valid_delay_line (a parameterised READ_LATENCY-deep shift register carrying valid plus a 3-bit tag: probe index or aux), is used to route returning data.

Test Plan:
- Ball 0x0A80,0x0A00 (xi=10, yi=10), map all fairway:
  - mem_addr sequence is 1290, 1292, 1288, 1034, 1546 in T+1..T+5.
  - done at T+8; all terrain=0; wall_x=wall_y=in_hole=0.
- Map cell 1292=WALL and 1290=HOLE, same ball → terrain_r=2, wall_x=1, in_hole=1, wall_y=0.
- Ball xi=1, yi=127 → l and d are out of bounds, forced WALL (wall_x=wall_y=1), and done timing is unchanged at T+8.
- start pulses again at T+3 and at T+8 → both ignored; exactly one done; the next start at T+9 is accepted.
- aux_req with aux_addr=500 while idle:
  - aux_gnt=1, aux_rvalid 2 cycles later with the cell's data.
  - aux_req and start in the same cycle → aux_gnt=0, probe proceeds.
- rst_in low at T+4 → busy=0 next cycle; no done; no aux_rvalid; outputs are 0.
